// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and default widths for the unified memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, IF_BUSY, DM_BUSY)
//   arb_port_e  : requester identity (PORT_IF, PORT_DM)
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default bus widths
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 32;
  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY
  } arb_state_e;

  typedef enum logic {
    PORT_IF,
    PORT_DM
  } arb_port_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch + data ports), the arbiter and the memory.
//   fetch port : if_req, if_addr, if_kill -> if_rdata, if_ack, if_stall
//   data port  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ack, dm_stall
//   memory     : mem_valid, mem_we, mem_addr, mem_wdata -> mem_done, mem_rdata
// Modport slave is the arbiter's view; master is the surrounding environment's view.
interface unified_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              dm_stall;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_rdata, if_ack, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack, dm_stall,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_done, mem_rdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_rdata, if_ack, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack, dm_stall,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_done, mem_rdata
  );

endinterface

// File: rtl/unified_mem_arbiter_pick.sv
// Combinational winner selection for the unified memory arbiter.
//   if_valid, dm_valid : active requests this cycle
//   last_grant         : port granted most recently (round-robin only)
//   grant_valid        : at least one request is active
//   grant_port         : winning port
// Build option ARB_ROUND_ROBIN_EN: on a tie the port not granted last wins;
// otherwise the data port always wins ties (older instruction goes first).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic      if_valid,
  input  logic      dm_valid,
  input  arb_port_e last_grant,
  output logic      grant_valid,
  output arb_port_e grant_port
);

  always_comb begin
    grant_valid = if_valid || dm_valid;
    grant_port  = PORT_DM;
    if (if_valid && dm_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_port = (last_grant == PORT_IF) ? PORT_DM : PORT_IF;
`else
      grant_port = PORT_DM;
`endif
    end else if (if_valid) begin
      grant_port = PORT_IF;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
// One transaction outstanding at a time; acks are registered and last one cycle.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : unified_mem_arbiter_if.slave (fetch, data and memory signals)
// Build option ARB_ROUND_ROBIN_EN enables a one-bit last-grant pointer for ties.
module unified_mem_arbiter
  import mem_arb_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       kill_pending_q, kill_pending_d;
  logic       if_ack_d, dm_ack_d;
  logic       if_valid, dm_valid, grant_valid, grant_now;
  arb_port_e  grant_port, last_grant;

  // A fetch being killed this cycle does not take part in arbitration.
  assign if_valid  = bus.if_req && !bus.if_kill;
  assign dm_valid  = bus.dm_req;
  assign grant_now = (state_q == IDLE) && grant_valid;

  mem_arb_pick u_pick (
    .if_valid    (if_valid),
    .dm_valid    (dm_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_IF;
    end else if (grant_now) begin
      last_grant <= grant_port;
    end
  end
`else
  assign last_grant = PORT_IF;
`endif

  always_comb begin
    state_d        = state_q;
    kill_pending_d = kill_pending_q;
    if_ack_d       = 1'b0;
    dm_ack_d       = 1'b0;
    case (state_q)
      IDLE: begin
        kill_pending_d = 1'b0;
        if (grant_valid) begin
          state_d = (grant_port == PORT_DM) ? DM_BUSY : IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (bus.if_kill) begin
          kill_pending_d = 1'b1;
        end
        // Memory cannot be aborted: a killed fetch still completes, silently.
        if (bus.mem_done) begin
          if_ack_d       = !(kill_pending_q || bus.if_kill);
          kill_pending_d = 1'b0;
          state_d        = IDLE;
        end
      end
      DM_BUSY: begin
        if (bus.mem_done) begin
          dm_ack_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      kill_pending_q <= 1'b0;
      bus.if_ack     <= 1'b0;
      bus.dm_ack     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.if_rdata   <= '0;
      bus.dm_rdata   <= '0;
    end else begin
      state_q        <= state_d;
      kill_pending_q <= kill_pending_d;
      bus.if_ack     <= if_ack_d;
      bus.dm_ack     <= dm_ack_d;
      if (grant_now) begin
        if (grant_port == PORT_DM) begin
          bus.mem_we    <= bus.dm_we;
          bus.mem_addr  <= bus.dm_addr;
          bus.mem_wdata <= bus.dm_wdata;
        end else begin
          bus.mem_we    <= 1'b0;
          bus.mem_addr  <= bus.if_addr;
          bus.mem_wdata <= '0;
        end
      end else if ((state_q != IDLE) && bus.mem_done) begin
        bus.mem_we <= 1'b0;
      end
      if (if_ack_d) begin
        bus.if_rdata <= bus.mem_rdata;
      end
      // Writes complete with an ack but leave dm_rdata untouched.
      if (dm_ack_d && !bus.mem_we) begin
        bus.dm_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_valid = (state_q != IDLE);
  assign bus.if_stall  = bus.if_req && !bus.if_ack;
  assign bus.dm_stall  = bus.dm_req && !bus.dm_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
// Honors ARB_ROUND_ROBIN_EN for the expected tie-break rule.
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state shared across scenarios.
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;
  arb_port_e   last_grant   = PORT_IF;
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Tie-break rule: data port wins, or alternate when round-robin is built in.
  function automatic arb_port_e pick_winner(input bit ifv, input bit dmv);
    if (ifv && !dmv) return PORT_IF;
    if (dmv && !ifv) return PORT_DM;
`ifdef ARB_ROUND_ROBIN_EN
    return (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
`else
    return PORT_DM;
`endif
  endfunction

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_done = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [127:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.mem_valid, bus.mem_we, bus.if_ack, bus.dm_ack, bus.if_stall, bus.dm_stall} !== 6'b0)
    begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {bus.mem_valid, bus.mem_we, bus.if_ack,
               bus.dm_ack, bus.if_stall, bus.dm_stall});
    end
    got = {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata};
    n_checks++;
    if (got !== 128'h0) begin
      n_errors++;
      $display("FAIL reset_data: got %h want 0", got);
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: mem_valid got %b want 0", bus.mem_valid);
    end
  endtask

  task automatic test_lone_fetch();
    @(negedge clk);  // cycle 1
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    #1;
    n_checks++;
    if ({bus.if_stall, bus.mem_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL fetch_c1: stall,valid got %b want 10", {bus.if_stall, bus.mem_valid});
    end
    @(negedge clk);  // cycle 2
    n_checks++;
    if ({bus.mem_valid, bus.mem_we, bus.if_stall, bus.if_ack} !== 4'b1010 ||
        bus.mem_addr !== 32'h40) begin
      n_errors++;
      $display("FAIL fetch_c2: valid,we,stall,ack=%b addr=%h want 1010 addr=40",
               {bus.mem_valid, bus.mem_we, bus.if_stall, bus.if_ack}, bus.mem_addr);
    end
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h0050_0093;
    @(negedge clk);  // cycle 3
    n_checks++;
    if ({bus.mem_valid, bus.if_ack, bus.dm_ack, bus.if_stall} !== 4'b0100 ||
        bus.if_rdata !== 32'h0050_0093) begin
      n_errors++;
      $display("FAIL fetch_c3: valid,ifack,dmack,stall=%b rdata=%h want 0100 rdata=00500093",
               {bus.mem_valid, bus.if_ack, bus.dm_ack, bus.if_stall}, bus.if_rdata);
    end
    bus.if_req = 1'b0; bus.mem_done = 1'b0;
    exp_if_rdata = 32'h0050_0093;
    last_grant = PORT_IF;
    @(negedge clk);  // cycle 4
    n_checks++;
    if ({bus.mem_valid, bus.if_ack} !== 2'b00 || bus.if_rdata !== exp_if_rdata) begin
      n_errors++;
      $display("FAIL fetch_hold: valid,ack=%b rdata=%h want 00 rdata=%h",
               {bus.mem_valid, bus.if_ack}, bus.if_rdata, exp_if_rdata);
    end
  endtask

  // Both ports request together with a zero-wait memory; with 'held' the
  // requesters keep asking after each ack.
  task automatic test_contention(input bit held, input int n);
    bit          if_on, dm_on, exp_ack;
    arb_port_e   cur;
    int          grants;
    logic [1:0]  want_ack;
    logic [31:0] want_addr, want_data, got_data;
    cur = PORT_IF;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200;
    if_on = 1'b1; dm_on = 1'b1; exp_ack = 1'b0; grants = 0;
    for (int c = 0; c < 40 && grants < n; c++) begin
      @(negedge clk);
      want_ack = exp_ack ? ((cur == PORT_DM) ? 2'b01 : 2'b10) : 2'b00;
      n_checks++;
      if ({bus.if_ack, bus.dm_ack} !== want_ack) begin
        n_errors++;
        $display("FAIL contend_ack: if,dm got %b want %b", {bus.if_ack, bus.dm_ack}, want_ack);
      end
      bus.mem_done = 1'b0;
      if (exp_ack) begin
        grants++;
        want_data = mem_rd((cur == PORT_DM) ? 32'h200 : 32'h10);
        got_data  = (cur == PORT_DM) ? bus.dm_rdata : bus.if_rdata;
        if (cur == PORT_DM) exp_dm_rdata = want_data;
        else exp_if_rdata = want_data;
        n_checks++;
        if (got_data !== want_data || bus.mem_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL contend_data: rdata=%h valid=%b want %h valid=0",
                   got_data, bus.mem_valid, want_data);
        end
        if (!held || grants == n) begin
          if (cur == PORT_DM || grants == n) begin bus.dm_req = 1'b0; dm_on = 1'b0; end
          if (cur == PORT_IF || grants == n) begin bus.if_req = 1'b0; if_on = 1'b0; end
        end
        exp_ack = 1'b0;
      end else if (bus.mem_valid) begin
        cur = pick_winner(if_on, dm_on);
        last_grant = cur;
        want_addr = (cur == PORT_DM) ? 32'h200 : 32'h10;
        n_checks++;
        if (bus.mem_addr !== want_addr || bus.mem_we !== 1'b0) begin
          n_errors++;
          $display("FAIL contend_grant %0d: addr=%h we=%b want addr=%h we=0",
                   grants, bus.mem_addr, bus.mem_we, want_addr);
        end
        bus.mem_done = 1'b1; bus.mem_rdata = mem_rd(bus.mem_addr);
        exp_ack = 1'b1;
      end
    end
    n_checks++;
    if (grants != n) begin
      n_errors++;
      $display("FAIL contend_count: got %0d grants want %0d", grants, n);
    end
    @(negedge clk);
    n_checks++;
    if (bus.mem_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL contend_quiet: mem_valid got %b want 0", bus.mem_valid);
    end
  endtask

  task automatic test_dm_write();
    @(negedge clk);
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h300; bus.dm_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mem_valid, bus.mem_we, bus.dm_ack, bus.dm_stall} !== 4'b1101 ||
          bus.mem_addr !== 32'h300 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
        n_errors++;
        $display("FAIL write_busy %0d: valid,we,ack,stall=%b addr=%h wdata=%h want 1101 300 deadbeef",
                 k, {bus.mem_valid, bus.mem_we, bus.dm_ack, bus.dm_stall}, bus.mem_addr,
                 bus.mem_wdata);
      end
      bus.mem_done  = (k == 3);
      bus.mem_rdata = 32'h1234_5678;
    end
    @(negedge clk);
    n_checks++;
    if ({bus.dm_ack, bus.if_ack, bus.mem_valid} !== 3'b100 || bus.dm_rdata !== exp_dm_rdata) begin
      n_errors++;
      $display("FAIL write_ack: dmack,ifack,valid=%b rdata=%h want 100 rdata=%h",
               {bus.dm_ack, bus.if_ack, bus.mem_valid}, bus.dm_rdata, exp_dm_rdata);
    end
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.mem_done = 1'b0;
    mem_model[32'h300] = 32'hDEAD_BEEF;
    last_grant = PORT_DM;
    @(negedge clk);
    n_checks++;
    if ({bus.dm_ack, bus.mem_valid} !== 2'b00) begin
      n_errors++;
      $display("FAIL write_once: ack,valid got %b want 00", {bus.dm_ack, bus.mem_valid});
    end
  endtask

  task automatic test_kill();
    logic [31:0] d;
    @(negedge clk);  // kill in IDLE excludes the fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.if_kill = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL kill_idle: mem_valid got %b want 0", bus.mem_valid);
    end
    bus.if_kill = 1'b0;
    @(negedge clk);  // fetch granted
    n_checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h80) begin
      n_errors++;
      $display("FAIL kill_grant: valid=%b addr=%h want 1 80", bus.mem_valid, bus.mem_addr);
    end
    last_grant = PORT_IF;
    bus.if_kill = 1'b1; bus.if_req = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_valid, bus.if_ack} !== 2'b10) begin
      n_errors++;
      $display("FAIL kill_busy: valid,ack got %b want 10", {bus.mem_valid, bus.if_ack});
    end
    bus.if_kill = 1'b0; bus.mem_done = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    n_checks++;
    if ({bus.if_ack, bus.dm_ack, bus.mem_valid} !== 3'b000 || bus.if_rdata !== exp_if_rdata) begin
      n_errors++;
      $display("FAIL kill_done: ifack,dmack,valid=%b rdata=%h want 000 rdata=%h",
               {bus.if_ack, bus.dm_ack, bus.mem_valid}, bus.if_rdata, exp_if_rdata);
    end
    bus.mem_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h400 || bus.mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL kill_next: valid=%b addr=%h we=%b want 1 400 0",
               bus.mem_valid, bus.mem_addr, bus.mem_we);
    end
    d = mem_rd(32'h400);
    bus.mem_done = 1'b1; bus.mem_rdata = d;
    @(negedge clk);
    n_checks++;
    if ({bus.dm_ack, bus.if_ack} !== 2'b10 || bus.dm_rdata !== d || bus.if_rdata !== exp_if_rdata)
    begin
      n_errors++;
      $display("FAIL kill_dm_ack: dmack,ifack=%b dm_rdata=%h if_rdata=%h want 10 %h %h",
               {bus.dm_ack, bus.if_ack}, bus.dm_rdata, bus.if_rdata, d, exp_if_rdata);
    end
    exp_dm_rdata = d;
    last_grant = PORT_DM;
    bus.dm_req = 1'b0; bus.mem_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h500;
    @(negedge clk);
    n_checks++;
    if (bus.mem_valid !== 1'b1 || dut.state_q !== DM_BUSY) begin
      n_errors++;
      $display("FAIL rstmid_busy: valid=%b state=%0d want 1 %0d", bus.mem_valid, dut.state_q,
               DM_BUSY);
    end
    rst = 1'b1; bus.dm_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_valid, bus.mem_we, bus.dm_ack, bus.if_ack} !== 4'b0 || dut.state_q !== IDLE ||
        {bus.mem_addr, bus.if_rdata, bus.dm_rdata} !== 96'h0) begin
      n_errors++;
      $display("FAIL rstmid_clear: valid,we,dmack,ifack=%b state=%0d addr=%h want 0000 IDLE 0",
               {bus.mem_valid, bus.mem_we, bus.dm_ack, bus.if_ack}, dut.state_q, bus.mem_addr);
    end
    rst = 1'b0; bus.mem_done = 1'b1; bus.mem_rdata = 32'hFEED_F00D;
    exp_if_rdata = '0; exp_dm_rdata = '0; last_grant = PORT_IF;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_valid, bus.dm_ack, bus.if_ack} !== 3'b000 || dut.state_q !== IDLE ||
        bus.dm_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL rstmid_late_done: valid,dmack,ifack=%b state=%0d rdata=%h want 000 IDLE 0",
               {bus.mem_valid, bus.dm_ack, bus.if_ack}, dut.state_q, bus.dm_rdata);
    end
    bus.mem_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.dm_ack, bus.if_ack} !== 2'b00) begin
      n_errors++;
      $display("FAIL rstmid_noack: acks got %b want 00", {bus.dm_ack, bus.if_ack});
    end
  endtask

  // Random traffic: model tracks the one open transaction at transaction level.
  task automatic test_random(input int n);
    logic        p_if_req, p_if_kill, p_dm_req, p_dm_we, p_done;
    logic [31:0] p_if_addr, p_dm_addr, p_dm_wdata;
    bit          busy, killed, ea_if, ea_dm;
    arb_port_e   port;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    p_if_req = 1'b0; p_if_kill = 1'b0; p_dm_req = 1'b0; p_dm_we = 1'b0; p_done = 1'b0;
    p_if_addr = '0; p_dm_addr = '0; p_dm_wdata = '0;
    busy = 1'b0; killed = 1'b0; port = PORT_IF; m_addr = '0; m_wdata = '0; m_we = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ea_if = 1'b0; ea_dm = 1'b0;
      if (busy) begin
        if (p_done) begin
          if (port == PORT_DM) begin
            ea_dm = 1'b1;
            if (!m_we) exp_dm_rdata = mem_rd(m_addr);
          end else if (!(killed || p_if_kill)) begin
            ea_if = 1'b1;
            exp_if_rdata = mem_rd(m_addr);
          end
          busy = 1'b0;
        end else if (port == PORT_IF && p_if_kill) begin
          killed = 1'b1;
        end
      end else if ((p_if_req && !p_if_kill) || p_dm_req) begin
        port = pick_winner(p_if_req && !p_if_kill, p_dm_req);
        last_grant = port;
        busy = 1'b1; killed = 1'b0;
        m_addr  = (port == PORT_DM) ? p_dm_addr : p_if_addr;
        m_we    = (port == PORT_DM) ? p_dm_we : 1'b0;
        m_wdata = p_dm_wdata;
      end
      n_checks++;
      if (bus.mem_valid !== busy) begin
        n_errors++;
        $display("FAIL rand_valid @%0d: got %b want %b", i, bus.mem_valid, busy);
      end
      if (busy) begin
        n_checks++;
        if (bus.mem_addr !== m_addr || bus.mem_we !== m_we ||
            (m_we && bus.mem_wdata !== m_wdata)) begin
          n_errors++;
          $display("FAIL rand_txn @%0d: addr=%h we=%b wdata=%h want %h %b %h", i, bus.mem_addr,
                   bus.mem_we, bus.mem_wdata, m_addr, m_we, m_wdata);
        end
      end
      n_checks++;
      if ({bus.if_ack, bus.dm_ack} !== {ea_if, ea_dm}) begin
        n_errors++;
        $display("FAIL rand_ack @%0d: if,dm got %b want %b", i, {bus.if_ack, bus.dm_ack},
                 {ea_if, ea_dm});
      end
      n_checks++;
      if (bus.if_rdata !== exp_if_rdata || bus.dm_rdata !== exp_dm_rdata) begin
        n_errors++;
        $display("FAIL rand_rdata @%0d: if=%h dm=%h want %h %h", i, bus.if_rdata, bus.dm_rdata,
                 exp_if_rdata, exp_dm_rdata);
      end
      n_checks++;
      if ({bus.if_stall, bus.dm_stall} !== {p_if_req && !ea_if, p_dm_req && !ea_dm}) begin
        n_errors++;
        $display("FAIL rand_stall @%0d: got %b want %b", i, {bus.if_stall, bus.dm_stall},
                 {p_if_req && !ea_if, p_dm_req && !ea_dm});
      end
      // Memory responder, including stray mem_done while idle.
      if (bus.mem_valid) begin
        bus.mem_done = ($urandom_range(0, 2) == 0);
        if (bus.mem_done && bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
        bus.mem_rdata = bus.mem_we ? $urandom : mem_rd(bus.mem_addr);
      end else begin
        bus.mem_done  = ($urandom_range(0, 7) == 0);
        bus.mem_rdata = $urandom;
      end
      // Fetch requester.
      bus.if_kill = 1'b0;
      if (bus.if_req && bus.if_ack) begin
        bus.if_req = 1'b0;
      end else if (bus.if_req && $urandom_range(0, 11) == 0) begin
        bus.if_kill = 1'b1; bus.if_req = 1'b0;
      end
      if (!bus.if_req && !bus.if_kill && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1'b1; bus.if_addr = $urandom_range(0, 15) << 2;
      end
      // Data requester.
      if (bus.dm_req && bus.dm_ack) bus.dm_req = 1'b0;
      if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
        bus.dm_req = 1'b1; bus.dm_we = 1'($urandom_range(0, 1));
        bus.dm_addr = $urandom_range(0, 15) << 2; bus.dm_wdata = $urandom;
      end
      p_if_req = bus.if_req; p_if_kill = bus.if_kill; p_if_addr = bus.if_addr;
      p_dm_req = bus.dm_req; p_dm_we = bus.dm_we; p_dm_addr = bus.dm_addr;
      p_dm_wdata = bus.dm_wdata; p_done = bus.mem_done;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lone_fetch();
    test_contention(1'b0, 2);
    test_contention(1'b1, 4);
    test_dm_write();
    test_kill();
    test_reset_mid();
    test_random(800);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
